// File: rtl/secuenciador_divisor_if.sv
// Bus between the divider sequencer and its surroundings: start/done handshake,
// operands and results, plus the operand/select/result lines of the 32-bit ALU.
interface secuenciador_divisor_if;
  logic        inicio;
  logic [15:0] dividendo;
  logic [15:0] divisor;
  logic [31:0] z;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] c;
  logic [15:0] chi;
  logic [3:0]  d;
  logic [2:0]  seleccion_operando;
  logic [2:0]  seleccion_operacion;
  logic        ocupado;
  logic        listo;
  logic [15:0] cociente;
  logic [15:0] residuo;
  logic        div_cero;

  modport master (
    output inicio, dividendo, divisor, z,
    input  a, b, c, chi, d, seleccion_operando, seleccion_operacion,
    input  ocupado, listo, cociente, residuo, div_cero
  );

  modport slave (
    input  inicio, dividendo, divisor, z,
    output a, b, c, chi, d, seleccion_operando, seleccion_operacion,
    output ocupado, listo, cociente, residuo, div_cero
  );
endinterface

// File: rtl/secuenciador_divisor.sv
// Sequencer and working registers for the signed 16/16 restoring divider.
// Divides magnitudes through the external ALU, then applies the signs.
//
// state    | meaning
// IDLE     | waiting for inicio
// ABS_A    | a <= |a| through the ALU when negative
// ABS_B    | b <= |b|; c <= {0, |a|}
// DESPLAZA | shift {remainder, quotient} left by one
// RESTA    | trial subtract chi - b; keep it and set quotient bit on success
// CUENTA   | d <= d + 1; after 16 iterations split c into a (quotient), b (remainder)
// NEG_Q    | cociente <= +/- a
// NEG_R    | residuo <= +/- b
// FIN      | listo pulse
module secuenciador_divisor (
  input  logic                  clk,
  input  logic                  reset,
  secuenciador_divisor_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ABS_A, ABS_B, DESPLAZA, RESTA, CUENTA, NEG_Q, NEG_R, FIN
  } estado_t;

  estado_t     estado;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [31:0] c_r;
  logic [3:0]  d_r;
  logic        sign_a;
  logic        sign_q;
  logic [2:0]  sel_operando;
  logic [2:0]  sel_operacion;
  logic        ocupado_r;
  logic        listo_r;
  logic [15:0] cociente_r;
  logic [15:0] residuo_r;
  logic        div_cero_r;
  logic        prueba_ok;
  logic        z_unused;

  // A set chi[15] means the shifted remainder already exceeds any 16-bit magnitude divisor.
  assign prueba_ok = c_r[31] | ~bus.z[31];
  assign z_unused  = ^bus.z[30:16];

  // Selects are registered, so they are loaded on the transition into the state that uses them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado        <= IDLE;
      a_r           <= '0;
      b_r           <= '0;
      c_r           <= '0;
      d_r           <= '0;
      sign_a        <= 1'b0;
      sign_q        <= 1'b0;
      sel_operando  <= '0;
      sel_operacion <= '0;
      ocupado_r     <= 1'b0;
      listo_r       <= 1'b0;
      cociente_r    <= '0;
      residuo_r     <= '0;
      div_cero_r    <= 1'b0;
    end else begin
      sel_operando  <= 3'b000;
      sel_operacion <= 3'b000;
      listo_r       <= 1'b0;
      case (estado)
        IDLE: begin
          if (bus.inicio) begin
            a_r       <= bus.dividendo;
            b_r       <= bus.divisor;
            d_r       <= 4'd0;
            sign_a    <= bus.dividendo[15];
            sign_q    <= bus.dividendo[15] ^ bus.divisor[15];
            ocupado_r <= 1'b1;
            if (bus.divisor == 16'h0000) begin
              cociente_r <= 16'hFFFF;
              residuo_r  <= bus.dividendo;
              div_cero_r <= 1'b1;
              listo_r    <= 1'b1;
              estado     <= FIN;
            end else begin
              div_cero_r <= 1'b0;
              estado     <= ABS_A;
              if (bus.dividendo[15]) begin
                sel_operando  <= 3'b001;
                sel_operacion <= 3'b100;
              end
            end
          end
        end
        ABS_A: begin
          if (a_r[15]) a_r <= bus.z[15:0];
          if (b_r[15]) begin
            sel_operando  <= 3'b010;
            sel_operacion <= 3'b100;
          end
          estado <= ABS_B;
        end
        ABS_B: begin
          if (b_r[15]) b_r <= bus.z[15:0];
          c_r    <= {16'h0000, a_r};
          estado <= DESPLAZA;
        end
        DESPLAZA: begin
          c_r           <= c_r << 1;
          sel_operando  <= 3'b101;
          sel_operacion <= 3'b010;
          estado        <= RESTA;
        end
        RESTA: begin
          if (prueba_ok) begin
            c_r[31:16] <= bus.z[15:0];
            c_r[0]     <= 1'b1;
          end
          sel_operando  <= 3'b110;
          sel_operacion <= 3'b011;
          estado        <= CUENTA;
        end
        CUENTA: begin
          d_r <= bus.z[3:0];
          if (d_r == 4'd15) begin
            a_r    <= c_r[15:0];
            b_r    <= c_r[31:16];
            estado <= NEG_Q;
            if (sign_q) begin
              sel_operando  <= 3'b001;
              sel_operacion <= 3'b100;
            end
          end else begin
            estado <= DESPLAZA;
          end
        end
        NEG_Q: begin
          cociente_r <= sign_q ? bus.z[15:0] : a_r;
          if (sign_a) begin
            sel_operando  <= 3'b010;
            sel_operacion <= 3'b100;
          end
          estado <= NEG_R;
        end
        NEG_R: begin
          residuo_r <= sign_a ? bus.z[15:0] : b_r;
          listo_r   <= 1'b1;
          estado    <= FIN;
        end
        FIN: begin
          ocupado_r <= 1'b0;
          estado    <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign bus.a                   = a_r;
  assign bus.b                   = b_r;
  assign bus.c                   = c_r;
  assign bus.chi                 = c_r[31:16];
  assign bus.d                   = d_r;
  assign bus.seleccion_operando  = sel_operando;
  assign bus.seleccion_operacion = sel_operacion;
  assign bus.ocupado             = ocupado_r;
  assign bus.listo               = listo_r;
  assign bus.cociente            = cociente_r;
  assign bus.residuo             = residuo_r;
  assign bus.div_cero            = div_cero_r;

endmodule
